// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU dispatch initiator.
// Holds the funct-field bit positions, the operation classes produced by
// the funct decoder, and the state encoding of the issue controller.
package fpu_pkg;

  localparam int FUNCT_W = 5;

  // Bit positions inside the 5-bit funct code.  With FN_EXT clear the low
  // four bits select the binary arithmetic ops; with FN_EXT set bits 3..1
  // select the unary ops (priority sqrt > itof > ftoi) and bit 0 selects
  // fless over feq when no unary bit is set.
  localparam int FN_ADD  = 0;
  localparam int FN_SUB  = 1;
  localparam int FN_MUL  = 2;
  localparam int FN_DIV  = 3;
  localparam int FN_EXT  = 4;
  localparam int FN_SQRT = 3;
  localparam int FN_ITOF = 2;
  localparam int FN_FTOI = 1;
  localparam int FN_LESS = 0;

  typedef enum logic [1:0] {
    OP_ARITH,
    OP_CMP,
    OP_ILLEGAL
  } op_class_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_ISSUE,
    ST_CMP,
    ST_WAIT_RES,
    ST_WB
  } issue_state_e;

endpackage

// File: rtl/fpu_funct_decode.sv
// Combinational funct classifier.
// Ports:
//   funct    - 5-bit FPU funct code from decode
//   op_class - OP_ARITH (multi-cycle unit, result on fpu_y),
//              OP_CMP (single-cycle compare, result on fpu_inst_y),
//              OP_ILLEGAL (no operation selected)
module fpu_funct_decode
  import fpu_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct,
  output op_class_e          op_class
);

  logic binary_sel;
  logic unary_sel;

  always_comb begin
    binary_sel = funct[FN_ADD] | funct[FN_SUB] | funct[FN_MUL] | funct[FN_DIV];
    unary_sel  = funct[FN_SQRT] | funct[FN_ITOF] | funct[FN_FTOI];
    op_class   = OP_ILLEGAL;
    if (funct[FN_EXT]) begin
      // fless/feq differ only in FN_LESS, which the FPU decodes itself.
      op_class = unary_sel ? OP_ARITH : OP_CMP;
    end else if (binary_sel) begin
      op_class = OP_ARITH;
    end
  end

endmodule

// File: rtl/fpu_issue.sv
// Initiator side of the FPU dispatch interface.
// Accepts one FP instruction at a time from decode, drives it to the FPU,
// waits for the result and hands it back on a writeback port.
// Ports:
//   clk, rstn             - clock, synchronous active-low reset
//   req_valid/req_ready   - decode handshake; ready only in IDLE
//   req_funct/x1/x2/rd    - instruction funct, operands, destination tag
//   wb_valid/wb_ready     - writeback handshake
//   wb_data/wb_rd/wb_err  - result, tag, illegal-funct or timeout flag
//   fpu_funct/x1/x2       - operands to the FPU, held while busy
//   fpu_en                - one-cycle start pulse for multi-cycle ops
//   fpu_y/fpu_valid       - multi-cycle result and its strobe
//   fpu_inst_y            - combinational compare result
//   fpu_idle              - every FPU unit idle; gates the start pulse
//   busy                  - controller not in IDLE
module fpu_issue
  import fpu_pkg::*;
#(
  parameter int TAG_W   = 6,
  parameter int CMP_LAT = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [FUNCT_W-1:0] req_funct,
  input  logic [31:0]        req_x1,
  input  logic [31:0]        req_x2,
  input  logic [TAG_W-1:0]   req_rd,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [31:0]        wb_data,
  output logic [TAG_W-1:0]   wb_rd,
  output logic               wb_err,
  output logic [FUNCT_W-1:0] fpu_funct,
  output logic [31:0]        fpu_x1,
  output logic [31:0]        fpu_x2,
  output logic               fpu_en,
  input  logic [31:0]        fpu_y,
  input  logic [31:0]        fpu_inst_y,
  input  logic               fpu_valid,
  input  logic               fpu_idle,
  output logic               busy
);

  // Counter value seen in the last allowed cycle of a waiting state.
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [15:0] CMP_LAST = 16'(CMP_LAT);

  issue_state_e state_q, state_d;
  op_class_e    op_class;

  logic [FUNCT_W-1:0] funct_q;
  logic [31:0]        x1_q;
  logic [31:0]        x2_q;
  logic [TAG_W-1:0]   rd_q;
  logic [31:0]        res_q;
  logic               err_q;
  logic [15:0]        cnt_q;
  logic               to_hit;
  logic               cmp_hit;
  logic               accept;

  fpu_funct_decode u_decode (
    .funct    (req_funct),
    .op_class (op_class)
  );

  assign accept  = (state_q == ST_IDLE) && req_valid;
  assign to_hit  = (cnt_q == TO_LAST);
  assign cmp_hit = (cnt_q == CMP_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          unique case (op_class)
            OP_ILLEGAL: state_d = ST_WB;
            OP_CMP:     state_d = ST_CMP;
            default:    state_d = ST_WAIT_IDLE;
          endcase
        end
      end
      ST_WAIT_IDLE: begin
        if (fpu_idle)    state_d = ST_ISSUE;
        else if (to_hit) state_d = ST_WB;
      end
      ST_ISSUE:    state_d = ST_WAIT_RES;
      ST_CMP:      if (cmp_hit) state_d = ST_WB;
      // A result arriving in the expiry cycle still counts as a result.
      ST_WAIT_RES: if (fpu_valid || to_hit) state_d = ST_WB;
      ST_WB:       if (wb_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs; FPU operands and writeback fields are forced to zero when not
  // meaningful so nothing stale leaks out after reset or between ops.
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    fpu_en    = (state_q == ST_ISSUE);
    wb_valid  = (state_q == ST_WB);
    wb_data   = '0;
    wb_rd     = '0;
    wb_err    = 1'b0;
    fpu_funct = '0;
    fpu_x1    = '0;
    fpu_x2    = '0;
    if (state_q != ST_IDLE) begin
      fpu_funct = funct_q;
      fpu_x1    = x1_q;
      fpu_x2    = x2_q;
    end
    if (state_q == ST_WB) begin
      wb_data = res_q;
      wb_rd   = rd_q;
      wb_err  = err_q;
    end
  end

  // Wait counter: restarts on every state change, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (!rstn)                   cnt_q <= '0;
    else if (state_d != state_q) cnt_q <= '0;
    else if (cnt_q != 16'hFFFF)  cnt_q <= cnt_q + 16'd1;
  end

  // Error flag
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE:      if (req_valid) err_q <= (op_class == OP_ILLEGAL);
        ST_WAIT_IDLE: if (!fpu_idle && to_hit) err_q <= 1'b1;
        ST_WAIT_RES:  if (!fpu_valid && to_hit) err_q <= 1'b1;
        default:      err_q <= err_q;
      endcase
    end
  end

  // Operand and result registers; only read while busy, so no reset.
  // res_q starts at zero on accept so error writebacks carry zero data.
  always_ff @(posedge clk) begin
    if (accept) begin
      funct_q <= req_funct;
      x1_q    <= req_x1;
      x2_q    <= req_x2;
      rd_q    <= req_rd;
      res_q   <= '0;
    end else if (state_q == ST_WAIT_RES && fpu_valid) begin
      res_q <= fpu_y;
    end else if (state_q == ST_CMP && cmp_hit) begin
      res_q <= fpu_inst_y;
    end
  end

endmodule

// File: tb/tb_fpu_issue.sv
// Directed bench for fpu_issue with a small latency-programmable FPU model.
module tb_fpu_issue;

  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rstn;
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_funct;
  logic [31:0]      req_x1;
  logic [31:0]      req_x2;
  logic [TAG_W-1:0] req_rd;
  logic             wb_valid;
  logic             wb_ready;
  logic [31:0]      wb_data;
  logic [TAG_W-1:0] wb_rd;
  logic             wb_err;
  logic [4:0]       fpu_funct;
  logic [31:0]      fpu_x1;
  logic [31:0]      fpu_x2;
  logic             fpu_en;
  logic [31:0]      fpu_y = '0;
  logic [31:0]      fpu_inst_y;
  logic             fpu_valid = 1'b0;
  logic             fpu_idle;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  // FPU model: fpu_valid rises model_lat cycles after the cycle of fpu_en
  // (model_lat >= 2), or never when model_lat is 0.
  int          model_lat = 3;
  logic [31:0] model_y   = '0;
  int          mcnt      = 0;
  int          en_pulses = 0;
  int          en_base;

  always #5 clk = ~clk;

  fpu_issue #(.TAG_W(TAG_W), .CMP_LAT(2), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct  (req_funct),
    .req_x1     (req_x1),
    .req_x2     (req_x2),
    .req_rd     (req_rd),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_data    (wb_data),
    .wb_rd      (wb_rd),
    .wb_err     (wb_err),
    .fpu_funct  (fpu_funct),
    .fpu_x1     (fpu_x1),
    .fpu_x2     (fpu_x2),
    .fpu_en     (fpu_en),
    .fpu_y      (fpu_y),
    .fpu_inst_y (fpu_inst_y),
    .fpu_valid  (fpu_valid),
    .fpu_idle   (fpu_idle),
    .busy       (busy)
  );

  always @(posedge clk) begin
    fpu_valid <= 1'b0;
    if (fpu_en) begin
      en_pulses <= en_pulses + 1;
      if (model_lat != 0) mcnt <= model_lat - 1;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        fpu_valid <= 1'b1;
        fpu_y     <= model_y;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request in the current cycle (cycle 0), return in cycle 1.
  task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] rd);
    req_valid = 1'b1;
    req_funct = f;
    req_x1    = a;
    req_x2    = b;
    req_rd    = rd;
    chkb("req_ready_at_accept", req_ready, 1'b1);
    step(1);
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rstn       = 1'b0;
    req_valid  = 1'b0;
    req_funct  = '0;
    req_x1     = '0;
    req_x2     = '0;
    req_rd     = '0;
    wb_ready   = 1'b1;
    fpu_inst_y = '0;
    fpu_idle   = 1'b1;
    step(2);
    chkb("rst_req_ready", req_ready, 1'b1);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_wb_valid", wb_valid, 1'b0);
    chkb("rst_fpu_en", fpu_en, 1'b0);
    chkw("rst_wb_data", wb_data, 32'h0);
    chkw("rst_fpu_x1", fpu_x1, 32'h0);
    rstn = 1'b1;

    // fadd 1.0 + 2.0 -> 3.0, result 3 cycles after the start pulse
    en_base = en_pulses;
    model_lat = 3;
    model_y = 32'h4040_0000;
    issue(5'b00001, 32'h3F80_0000, 32'h4000_0000, 6'd5);
    chkb("add_busy", busy, 1'b1);
    chkb("add_req_ready_busy", req_ready, 1'b0);
    chkb("add_en_c1", fpu_en, 1'b0);
    chkw("add_fpu_funct", 32'(fpu_funct), 32'h1);
    chkw("add_fpu_x1", fpu_x1, 32'h3F80_0000);
    chkw("add_fpu_x2", fpu_x2, 32'h4000_0000);
    step(1);
    chkb("add_en_c2", fpu_en, 1'b1);
    step(1);
    chkb("add_en_c3", fpu_en, 1'b0);
    step(2);
    chkb("add_wb_valid_c5", wb_valid, 1'b0);
    step(1);
    chkb("add_wb_valid_c6", wb_valid, 1'b1);
    chkw("add_wb_data", wb_data, 32'h4040_0000);
    chkw("add_wb_rd", 32'(wb_rd), 32'd5);
    chkb("add_wb_err", wb_err, 1'b0);
    chkb("add_req_ready_wb", req_ready, 1'b0);
    step(1);
    chkb("add_wb_valid_done", wb_valid, 1'b0);
    chkb("add_idle_ready", req_ready, 1'b1);
    chkw("add_idle_funct", 32'(fpu_funct), 32'h0);
    chkw("add_en_count", en_pulses - en_base, 32'd1);

    // fmul while the FPU reports busy for five cycles
    en_base = en_pulses;
    fpu_idle = 1'b0;
    model_y = 32'h40C0_0000;
    issue(5'b00100, 32'h4000_0000, 32'h4040_0000, 6'd9);
    for (int i = 1; i <= 5; i++) begin
      chkb("mul_en_gated", fpu_en, 1'b0);
      step(1);
    end
    fpu_idle = 1'b1;
    chkb("mul_en_c6", fpu_en, 1'b0);
    step(1);
    chkb("mul_en_c7", fpu_en, 1'b1);
    step(1);
    chkb("mul_en_c8", fpu_en, 1'b0);
    step(3);
    chkb("mul_wb_valid", wb_valid, 1'b1);
    chkw("mul_wb_data", wb_data, 32'h40C0_0000);
    chkw("mul_wb_rd", 32'(wb_rd), 32'd9);
    step(1);
    chkw("mul_en_count", en_pulses - en_base, 32'd1);

    // feq: inst_y must be sampled in cycle 1+CMP_LAT
    en_base = en_pulses;
    fpu_inst_y = 32'hDEAD_BEEF;
    issue(5'b10000, 32'h3F80_0000, 32'h3F80_0000, 6'd3);
    chkw("feq_fpu_funct", 32'(fpu_funct), 32'h10);
    step(1);
    chkb("feq_wb_valid_c2", wb_valid, 1'b0);
    step(1);
    fpu_inst_y = 32'h1;
    chkb("feq_wb_valid_c3", wb_valid, 1'b0);
    chkb("feq_en_c3", fpu_en, 1'b0);
    step(1);
    fpu_inst_y = 32'h55;
    chkb("feq_wb_valid_c4", wb_valid, 1'b1);
    chkw("feq_wb_data", wb_data, 32'h1);
    chkb("feq_wb_err", wb_err, 1'b0);
    chkw("feq_wb_rd", 32'(wb_rd), 32'd3);
    step(1);

    // fless 1.0 < 2.0 with model answering 0
    fpu_inst_y = 32'h1234;
    issue(5'b10001, 32'h3F80_0000, 32'h4000_0000, 6'd4);
    step(2);
    fpu_inst_y = 32'h0;
    step(1);
    chkb("fless_wb_valid", wb_valid, 1'b1);
    chkw("fless_wb_data", wb_data, 32'h0);
    step(1);
    chkw("cmp_en_count", en_pulses - en_base, 32'd0);

    // illegal funct: immediate error writeback
    en_base = en_pulses;
    issue(5'b00000, 32'h1, 32'h2, 6'd7);
    chkb("ill_wb_valid", wb_valid, 1'b1);
    chkb("ill_wb_err", wb_err, 1'b1);
    chkw("ill_wb_data", wb_data, 32'h0);
    chkw("ill_wb_rd", 32'(wb_rd), 32'd7);
    step(1);
    chkb("ill_req_ready", req_ready, 1'b1);
    chkw("ill_en_count", en_pulses - en_base, 32'd0);

    // fsub with no FPU response: timeout after 16 cycles in WAIT_RES
    model_lat = 0;
    issue(5'b00010, 32'h4000_0000, 32'h3F80_0000, 6'd11);
    step(17);
    chkb("to_wb_valid_c18", wb_valid, 1'b0);
    chkb("to_busy_c18", busy, 1'b1);
    step(1);
    chkb("to_wb_valid_c19", wb_valid, 1'b1);
    chkb("to_wb_err", wb_err, 1'b1);
    chkw("to_wb_data", wb_data, 32'h0);
    chkw("to_wb_rd", 32'(wb_rd), 32'd11);
    step(1);

    // itof after a timeout proceeds normally
    model_lat = 3;
    model_y = 32'h4000_0000;
    issue(5'b10100, 32'h0, 32'h2, 6'd12);
    step(5);
    chkb("itof_wb_valid", wb_valid, 1'b1);
    chkw("itof_wb_data", wb_data, 32'h4000_0000);
    chkb("itof_wb_err", wb_err, 1'b0);
    step(1);

    // result arrives in the last timeout cycle: result wins
    model_lat = 16;
    model_y = 32'h4180_0000;
    issue(5'b00001, 32'h4100_0000, 32'h4100_0000, 6'd13);
    step(17);
    chkb("race_wb_valid_c18", wb_valid, 1'b0);
    step(1);
    chkb("race_wb_valid_c19", wb_valid, 1'b1);
    chkb("race_wb_err", wb_err, 1'b0);
    chkw("race_wb_data", wb_data, 32'h4180_0000);
    step(1);

    // sqrt with writeback stalled for four cycles
    model_lat = 3;
    model_y = 32'h4000_0000;
    wb_ready = 1'b0;
    issue(5'b11000, 32'h0, 32'h4080_0000, 6'd20);
    step(5);
    for (int i = 0; i < 4; i++) begin
      chkb("sqrt_stall_valid", wb_valid, 1'b1);
      chkw("sqrt_stall_data", wb_data, 32'h4000_0000);
      chkw("sqrt_stall_rd", 32'(wb_rd), 32'd20);
      chkb("sqrt_stall_req_ready", req_ready, 1'b0);
      chkw("sqrt_stall_x2", fpu_x2, 32'h4080_0000);
      step(1);
    end
    wb_ready = 1'b1;
    chkb("sqrt_hs_valid", wb_valid, 1'b1);
    chkb("sqrt_hs_req_ready", req_ready, 1'b0);
    step(1);
    chkb("sqrt_done_valid", wb_valid, 1'b0);
    chkb("sqrt_done_req_ready", req_ready, 1'b1);

    // reset in WAIT_RES abandons the op
    model_lat = 0;
    issue(5'b01000, 32'h4040_0000, 32'h4000_0000, 6'd21);
    step(2);
    chkb("mid_busy", busy, 1'b1);
    rstn = 1'b0;
    step(1);
    chkb("mid_rst_req_ready", req_ready, 1'b1);
    chkb("mid_rst_busy", busy, 1'b0);
    chkb("mid_rst_wb_valid", wb_valid, 1'b0);
    chkb("mid_rst_en", fpu_en, 1'b0);
    chkw("mid_rst_x1", fpu_x1, 32'h0);
    chkw("mid_rst_funct", 32'(fpu_funct), 32'h0);
    rstn = 1'b1;

    // normal operation after the abandoned op
    model_lat = 3;
    model_y = 32'h4080_0000;
    issue(5'b00001, 32'h4000_0000, 32'h4000_0000, 6'd22);
    step(5);
    chkb("post_wb_valid", wb_valid, 1'b1);
    chkw("post_wb_data", wb_data, 32'h4080_0000);
    chkw("post_wb_rd", 32'(wb_rd), 32'd22);
    chkb("post_wb_err", wb_err, 1'b0);
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
